calc_port_responder: RTL and testbench

//  Single-port calculator responder: the DUT-side end of the calc request/response protocol.

---
 rtl/calc_port_responder_if.sv | 22 ++
 rtl/calc_port_responder.sv | 140 ++++++++++++++
 tb/tb_calc_port_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/calc_port_responder_if.sv
// Request/response bundle between a calc requester and the calc_port_responder.
interface calc_port_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned CMD_WIDTH  = 4
);
    logic [CMD_WIDTH-1:0]  req_cmd_in;
    logic [DATA_WIDTH-1:0] req_data_in;
    logic [RESP_WIDTH-1:0] out_resp;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  cmd_dropped;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, cmd_dropped
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, cmd_dropped
    );
endinterface

// File: rtl/calc_port_responder.sv
// Single-port calculator responder: takes a command with two operands on consecutive
// cycles and returns a one-cycle response a fixed number of cycles later.
module calc_port_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_port_responder_if.slave bus
);
    localparam int unsigned SHW   = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W = 4;
    localparam bit          SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RESP_WIDTH-1:0] resp_q, resp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  drop_q, drop_d;

    logic [DATA_WIDTH-1:0] op2_sel_c;
    logic [DATA_WIDTH:0]   sum_c;
    logic [SHW-1:0]        shamt_c;
    logic [RESP_WIDTH-1:0] calc_resp_c;
    logic [DATA_WIDTH-1:0] calc_data_c;

    // Operand 2 bypasses its register when the response is due straight out of OP2
    assign op2_sel_c = (state_q == OP2) ? bus.req_data_in : op2_q;
    assign sum_c     = {1'b0, op1_q} + {1'b0, op2_sel_c};
    assign shamt_c   = op2_sel_c[SHW-1:0];

    // Result and response code from the latched command and operands
    always_comb begin
        calc_resp_c = RESP_WIDTH'(2);
        calc_data_c = '0;
        case (cmd_q)
            CMD_WIDTH'(1): begin
                if (!sum_c[DATA_WIDTH]) begin
                    calc_resp_c = RESP_WIDTH'(1);
                    calc_data_c = sum_c[DATA_WIDTH-1:0];
                end
            end
            CMD_WIDTH'(2): begin
                if (op2_sel_c <= op1_q) begin
                    calc_resp_c = RESP_WIDTH'(1);
                    calc_data_c = op1_q - op2_sel_c;
                end
            end
            CMD_WIDTH'(5): begin
                calc_resp_c = RESP_WIDTH'(1);
                calc_data_c = op1_q << shamt_c;
            end
            CMD_WIDTH'(6): begin
                calc_resp_c = RESP_WIDTH'(1);
                calc_data_c = op1_q >> shamt_c;
            end
            default: ;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = '0;
        data_d  = '0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_cmd_in != '0) begin
                    cmd_d   = bus.req_cmd_in;
                    op1_d   = bus.req_data_in;
                    state_d = OP2;
                end
            end
            OP2: begin
                op2_d = bus.req_data_in;
                cnt_d = CNT_W'(LATENCY - 1);
                if (SINGLE_CYCLE) begin
                    resp_d  = calc_resp_c;
                    data_d  = calc_data_c;
                    state_d = RESP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d  = cnt_q - CNT_W'(1);
                drop_d = (bus.req_cmd_in != '0);
                // Register the result as the count expires so it shows in the RESP cycle
                if (cnt_q == CNT_W'(1)) begin
                    resp_d  = calc_resp_c;
                    data_d  = calc_data_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                drop_d  = (bus.req_cmd_in != '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.out_resp    = resp_q;
    assign bus.out_data    = data_q;
    assign bus.cmd_dropped = drop_q;
endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder: directed cases then random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_calc_port_responder;
    localparam int unsigned DW   = 32;
    localparam int          L    = 3;
    localparam int          MAXC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_port_responder_if #(.DATA_WIDTH(DW), .RESP_WIDTH(2), .CMD_WIDTH(4)) bus ();

    calc_port_responder #(
        .DATA_WIDTH(DW), .RESP_WIDTH(2), .CMD_WIDTH(4), .LATENCY(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Expected outputs per cycle, filled in by the model as requests are issued
    logic [1:0]  exp_resp [MAXC];
    logic [31:0] exp_data [MAXC];
    logic        exp_drop [MAXC];

    bit          pending   = 1'b0;
    int          busy_end  = -1;
    int          op2_cycle = 0;
    int          resp_cycle = 0;
    logic [3:0]  p_cmd;
    logic [31:0] p_op1;

    function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] s;
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd1: begin
                s = {32'd0, a} + {32'd0, b};
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5: return {2'd1, a << sh};
            4'd6: return {2'd1, a >> sh};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Check outputs of the current cycle, drive this cycle's inputs, update the model, advance
    task automatic step(input logic [3:0] c, input logic [31:0] d, input logic r);
        checks++;
        assert (bus.out_resp === exp_resp[k]) else begin
            errors++;
            $error("FAIL out_resp cycle %0d: got %0d expected %0d", k, bus.out_resp, exp_resp[k]);
        end
        checks++;
        assert (bus.out_data === exp_data[k]) else begin
            errors++;
            $error("FAIL out_data cycle %0d: got %h expected %h", k, bus.out_data, exp_data[k]);
        end
        checks++;
        assert (bus.cmd_dropped === exp_drop[k]) else begin
            errors++;
            $error("FAIL cmd_dropped cycle %0d: got %0d expected %0d", k, bus.cmd_dropped, exp_drop[k]);
        end

        bus.req_cmd_in  = c;
        bus.req_data_in = d;
        rst = r;

        if (r) begin
            for (int j = k + 1; j < MAXC; j++) begin
                exp_resp[j] = 2'd0;
                exp_data[j] = 32'd0;
                exp_drop[j] = 1'b0;
            end
            pending  = 1'b0;
            busy_end = -1;
        end else if (pending && k == op2_cycle) begin
            {exp_resp[resp_cycle], exp_data[resp_cycle]} = ref_calc(p_cmd, p_op1, d);
            pending = 1'b0;
        end else if (c != 4'd0) begin
            if (k > busy_end) begin
                pending    = 1'b1;
                p_cmd      = c;
                p_op1      = d;
                op2_cycle  = k + 1;
                resp_cycle = k + 1 + L;
                busy_end   = resp_cycle;
            end else begin
                exp_drop[k + 1] = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        k++;
        if (k >= MAXC - L - 4) begin
            errors++;
            $display("FAIL cycle_budget: reached cycle %0d limit %0d", k, MAXC);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Full transaction: command + op1, op2 next cycle, then idle until the bus is free again
    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        step(c, a, 1'b0);
        step(4'd0, b, 1'b0);
        repeat (L + 1) step(4'd0, $urandom, 1'b0);
    endtask

    initial begin
        for (int j = 0; j < MAXC; j++) begin
            exp_resp[j] = 2'd0;
            exp_data[j] = 32'd0;
            exp_drop[j] = 1'b0;
        end
        rst = 1'b1;
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;
        @(posedge clk);
        #1;

        step(4'd0, 32'd0, 1'b1);
        step(4'd0, 32'd0, 1'b0);
        step(4'd0, 32'd0, 1'b0);

        op(4'd1, 32'h10, 32'h20);
        op(4'd1, 32'hFFFF_FFFF, 32'h1);
        op(4'd2, 32'd7, 32'd5);
        op(4'd2, 32'd5, 32'd7);
        op(4'd5, 32'h1, 32'd31);
        op(4'd6, 32'h8000_0000, 32'h24);
        op(4'd3, 32'd1, 32'd2);
        op(4'd5, 32'h1234_5678, 32'hFFFF_FFE0);

        // Command during the operand-2 cycle is not a drop
        step(4'd1, 32'd3, 1'b0);
        step(4'd2, 32'd4, 1'b0);
        repeat (L + 1) step(4'd0, 32'd0, 1'b0);

        // Busy drop, then back-to-back acceptance at T+5
        step(4'd1, 32'd1, 1'b0);
        step(4'd0, 32'd2, 1'b0);
        step(4'd1, 32'd5, 1'b0);
        step(4'd0, 32'd0, 1'b0);
        step(4'd0, 32'd0, 1'b0);
        op(4'd1, 32'd3, 32'd4);

        // Reset abandons the in-flight request; the next one follows normal timing
        step(4'd1, 32'd1, 1'b0);
        step(4'd0, 32'd2, 1'b0);
        step(4'd0, 32'd0, 1'b1);
        op(4'd1, 32'd7, 32'd8);
        repeat (4) step(4'd0, 32'd0, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            logic [3:0]  c;
            logic [31:0] d;
            int          p;
            p = int'($urandom_range(0, 9));
            case (p)
                5: c = 4'd1;
                6: c = 4'd2;
                7: c = 4'd5;
                8: c = 4'd6;
                9: c = 4'($urandom_range(1, 15));
                default: c = 4'd0;
            endcase
            case ($urandom_range(0, 7))
                0: d = 32'd0;
                1: d = 32'hFFFF_FFFF;
                2: d = 32'h8000_0000;
                3: d = 32'($urandom_range(0, 40));
                default: d = $urandom;
            endcase
            step(c, d, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end
        repeat (L + 3) step(4'd0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
